// File: rtl/fact_mmio.sv
// rtl/fact_mmio.sv - memory-mapped iterative factorial accelerator (optional FACT_OVF_ERR_EN overflow error)
module fact_mmio #(
    parameter logic [31:0] BASE = 32'h0000_0800,
    parameter int          NW   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [NW-1:0]   n_reg;
    logic [NW-1:0]   cnt;
    logic [31:0]     prod;
    logic [31:0]     result;
    logic            done;
    logic            err;

    logic            hit;
    logic [1:0]      sel;
    logic            wr_n;
    logic            start;
    logic            busy;
    logic [31:0]     n_ext;
    logic [31:0]     cnt_ext;
    logic            unused_bits;

    assign hit     = (a[31:4] == BASE[31:4]);
    assign sel     = a[3:2];
    assign wr_n    = we && hit && (sel == 2'd0);
    assign start   = we && hit && (sel == 2'd1) && wd[0];
    assign busy    = (state == BUSY);
    assign n_ext   = {{(32-NW){1'b0}}, n_reg};
    assign cnt_ext = {{(32-NW){1'b0}}, cnt};
    assign unused_bits = ^{a[1:0], wd[31:NW]};

    always_comb begin
        rd = 32'd0;
        if (hit) begin
            case (sel)
                2'd0:    rd = n_ext;
                2'd2:    rd = {29'd0, err, busy, done};
                2'd3:    rd = result;
                default: rd = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            n_reg  <= '0;
            cnt    <= '0;
            prod   <= 32'd1;
            result <= 32'd0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            // N stays writable while busy; the running cnt is a private copy
            if (wr_n)
                n_reg <= wd[NW-1:0];
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cnt  <= n_reg;
                        prod <= 32'd1;
                        err  <= 1'b0;
                        done <= 1'b0;
                        state <= BUSY;
`ifdef FACT_OVF_ERR_EN
                        // 13! and above cannot fit in 32 bits: report instead of computing
                        if (n_ext > 32'd12) begin
                            err    <= 1'b1;
                            result <= 32'd0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
`endif
                    end
                end
                BUSY: begin
                    if (cnt_ext > 32'd1) begin
                        prod <= prod * cnt_ext;
                        cnt  <= cnt - NW'(1);
                    end else begin
                        result <= prod;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fact_mmio.sv
// tb/tb_fact_mmio.sv - self-checking bench for fact_mmio against a factorial reference model
module tb_fact_mmio;

    localparam logic [31:0] BASE = 32'h0000_0800;
    localparam logic [31:0] A_N  = BASE + 32'h0;
    localparam logic [31:0] A_GO = BASE + 32'h4;
    localparam logic [31:0] A_ST = BASE + 32'h8;
    localparam logic [31:0] A_RS = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic [31:0] a   = 32'd0;
    logic [31:0] wd  = 32'd0;
    logic [31:0] rd;

    int errors = 0;
    int checks = 0;

    fact_mmio #(.BASE(BASE), .NW(4)) dut (
        .clk(clk), .rst(rst), .we(we), .a(a), .wd(wd), .rd(rd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_fact(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 2; i <= n; i++) p = p * 32'(i);
        return p;
    endfunction

    function automatic bit ref_ovf(input int n);
`ifdef FACT_OVF_ERR_EN
        return n > 12;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        we = 1'b1; a = addr; wd = data;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        a = addr;
        #1;
        check(tag, rd, exp);
    endtask

    task automatic tick(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Write N, start, and confirm busy for max(n,1) cycles then done with n!
    task automatic run_fact(input int n);
        int lat;
        lat = (n > 1) ? n : 1;
        wr(A_N, 32'(n));
        wr(A_GO, 32'd1);
        if (ref_ovf(n)) begin
            tick(1);
            rd_check($sformatf("ovf_status_n%0d", n), A_ST, 32'h5);
            rd_check($sformatf("ovf_result_n%0d", n), A_RS, 32'h0);
        end else begin
            for (int k = 0; k < lat; k++) begin
                rd_check($sformatf("busy_n%0d_c%0d", n, k), A_ST, 32'h2);
                if (k < lat - 1) tick(1);
            end
            tick(1);
            rd_check($sformatf("done_n%0d", n), A_ST, 32'h1);
            rd_check($sformatf("result_n%0d", n), A_RS, ref_fact(n));
        end
    endtask

    initial begin
        tick(2);
        rd_check("reset_status", A_ST, 32'h0);
        rd_check("reset_result", A_RS, 32'h0);
        rd_check("reset_n", A_N, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);

        run_fact(5);
        rd_check("n5_result_const", A_RS, 32'h0000_0078);
        run_fact(0);
        run_fact(1);
        run_fact(12);
        rd_check("n12_result_const", A_RS, 32'h1C8C_FC00);
        run_fact(13);
`ifndef FACT_OVF_ERR_EN
        rd_check("n13_wrap_const", A_RS, 32'h7328_CC00);
`endif
        for (int r = 0; r < 6; r++) run_fact(int'($urandom_range(0, 15)));

        // start and N write while busy: running computation is unaffected
        wr(A_N, 32'd7);
        wr(A_GO, 32'd1);
        wr(A_N, 32'd3);
        wr(A_GO, 32'd1);
        tick(4);
        rd_check("ignore_go_busy", A_ST, 32'h2);
        tick(1);
        rd_check("ignore_go_done", A_ST, 32'h1);
        rd_check("ignore_go_result", A_RS, 32'h0000_13B0);
        rd_check("n_updated_busy", A_N, 32'd3);

        // reset mid-computation
        wr(A_N, 32'd9);
        wr(A_GO, 32'd1);
        tick(1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rd_check("rst_mid_status", A_ST, 32'h0);
        rd_check("rst_mid_result", A_RS, 32'h0);
        rd_check("rst_mid_n", A_N, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_fact(4);
        rd_check("after_rst_result", A_RS, 32'h18);

        // decode boundaries and read-only registers
        wr(BASE + 32'h10, 32'd11);
        wr(BASE - 32'h4, 32'd11);
        wr(BASE + 32'h14, 32'd1);
        wr(A_RS, 32'hDEAD_BEEF);
        wr(A_ST, 32'hFFFF_FFFF);
        rd_check("outside_hi_rd", BASE + 32'h10, 32'h0);
        rd_check("outside_lo_rd", BASE - 32'h4, 32'h0);
        rd_check("outside_n_kept", A_N, 32'd4);
        rd_check("outside_status_kept", A_ST, 32'h1);
        rd_check("ro_result_kept", A_RS, 32'h18);
        rd_check("go_reads_zero", A_GO, 32'h0);
        rd_check("byte_offset_ignored", BASE + 32'h1, 32'd4);
        wr(BASE + 32'h3, 32'd6);
        rd_check("byte_offset_write", A_N, 32'd6);
        run_fact(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
